lsu_cache_adapter: RTL and testbench
====================================

Name: lsu_cache_adapter

Overview:
- Load/store adapter between the CPU memory stage and the direct-mapped write-through data cache (word-only interface).
- Converts RV32I LB/LH/LW/LBU/LHU/SB/SH/SW into single-cycle-pulsed, word-aligned cache transactions.
- Performs sub-word stores as read-modify-write, and sign/zero-extends load data.
- Stalls the pipeline until each transaction completes.

Parameters:
- ADDR_WIDTH, 32, byte address width.
- DATA_WIDTH, 32, word width; only 32 is supported.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous reset, active-high.
- req_valid  in  1  memory-stage op present; held stable by the pipeline while stall=1.
- req_we  in  1  1=store, 0=load.
- req_funct3  in  3  RV32I funct3 of the load/store.
- req_addr  in  ADDR_WIDTH  byte address.
- req_w_data  in  DATA_WIDTH  store data (rs2).
- stall  out  1  freeze pipeline.
- load_data  out  DATA_WIDTH  extended load result; valid when done=1.
- done  out  1  one-cycle completion pulse.
- misaligned  out  1  misaligned access flag; valid with done (optional feature only).
- c_valid  out  1  cache request, one-cycle pulse.
- c_we  out  1  cache write enable.
- c_addr  out  ADDR_WIDTH  word-aligned cache address (bits [1:0]=0).
- c_w_data  out  DATA_WIDTH  full word to write.
- c_r_data  in  DATA_WIDTH  cache read data; valid when c_ready=1.
- c_ready  in  1  cache completion, one-cycle pulse.

Behaviour:
- Reset values: state=IDLE; c_valid=0, c_we=0, c_addr=0, c_w_data=0, load_data=0, done=0, misaligned=0.
- Reset mid-transaction aborts to IDLE. The cache shares rst, so no handshake is left dangling.
- c_valid, c_we, c_addr, c_w_data, load_data, done and misaligned are all registered.
- stall is combinational: stall = req_valid && (state != DONE).
- IDLE:
  - req_valid=1: latch funct3, addr[1:0] and w_data. Drive c_addr={addr[31:2],2'b00} and c_valid=1 for exactly the next cycle.
  - Load or SB/SH: c_we=0, go RD_WAIT; set rmw=1 for a store.
  - SW: c_we=1, c_w_data=req_w_data, go WR_WAIT.
- RD_WAIT:
  - c_valid=0; c_addr held stable. c_valid must never stay high across cycles, or the cache re-issues the request.
  - On c_ready with rmw=0: load_data = extracted and extended c_r_data, done=1, go DONE.
  - On c_ready with rmw=1: c_w_data = merge(c_r_data), c_we=1, c_valid pulse, go WR_WAIT.
- WR_WAIT: on c_ready, done=1, go DONE.
- DONE: stall=0 for one cycle (pipeline advances), then unconditionally go IDLE. done and misaligned are high only in this cycle.
- Load extraction (byte lane b=addr[1:0], half lane h=addr[1]):
  - LB/LBU: c_r_data[8b+7:8b], sign-/zero-extended.
  - LH/LHU: c_r_data[16h+15:16h], sign-/zero-extended.
  - LW: full word.
  - funct3 3/6/7 on a load: treated as LW.
- Store merge:
  - SB: replace byte lane b with w_data[7:0].
  - SH: replace half lane h with w_data[15:0].
  - Store funct3[1:0]=3: treated as SW.
- Latency from req_valid in IDLE to the DONE cycle, cache hit:
  - load = 3 cycles (DONE at cycle 3).
  - SW = 3 cycles.
  - SB/SH = 5 cycles.
- A read miss adds the cache's 4-cycle line fill (load miss: DONE at cycle 7).
- req_valid=0 in IDLE: no cache activity, stall=0.
- Back-to-back requests: a new request is accepted in the IDLE cycle after DONE. Throughput is bounded by that IDLE cycle.
- A write miss still completes through c_ready (no allocate); handled identically to a hit.
- RMW is not atomic against other masters; this core has a single master only.

Optional Feature:
- Macro: LSU_MISALIGN_CHECK_EN.
- Defined:
  - LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]!=0, is misaligned.
  - No cache request is issued; next state is DONE with done=1, misaligned=1 and load_data=0. Memory is unmodified.
- Not defined:
  - misaligned tied to 0.
  - Halfword ops use addr[1] only; word ops ignore addr[1:0]. The access proceeds normally.

Test Plan:
- Preload word 0x8000_FF7F at 0x100 (cache hit), LB addr 0x100 -> done at cycle 3, load_data=0x0000_007F; LB 0x101 -> 0xFFFF_FFFF; LBU 0x101 -> 0x0000_00FF.
- Same word, LH 0x102 -> load_data=0xFFFF_8000; LHU 0x102 -> 0x0000_8000; stall high exactly cycles 0-2.
- SB addr 0x203, data 0x0000_00AB, word 0x1122_3344 -> c_we=0 read pulse, then c_we=1 write 0xAB22_3344 to c_addr 0x200; done at cycle 5; LW 0x200 returns 0xAB22_3344.
- LW to a cold line 0x400 (miss) -> exactly one c_valid pulse; done only after c_ready (cycle 7); load_data equals RAM word.
- SW then immediate LW same address, back to back -> second request accepted in IDLE after DONE; returns the stored value; never two c_valid pulses in adjacent cycles.
- rst asserted during RD_WAIT -> all outputs 0, state IDLE next cycle. With LSU_MISALIGN_CHECK_EN, LW 0x102 -> no c_valid, done=1, misaligned=1 at cycle 1.

Source files
------------

// File: rtl/lsu_cache_adapter.sv
// ----------------------------------------------------------------------------
// lsu_cache_adapter
//
// Load/store adapter between the CPU memory stage and a word-only, write-through
// data cache. RV32I LB/LH/LW/LBU/LHU/SB/SH/SW are turned into single-cycle-pulsed,
// word-aligned cache transactions. Sub-word stores are done as read-modify-write
// and load data is sign/zero-extended. The pipeline is stalled until the access
// completes.
//
// Optional feature macro: LSU_MISALIGN_CHECK_EN
//   defined   : misaligned half/word accesses issue no cache request and finish
//               at once with done=1, misaligned=1, load_data=0.
//   undefined : misaligned is tied low; halfword ops use addr[1] only and word
//               ops ignore addr[1:0].
//
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   req_valid/we/funct3   memory-stage request (held stable while stall=1)
//   req_addr, req_w_data  byte address and store data (rs2)
//   stall                 combinational pipeline freeze
//   load_data, done       extended load result and one-cycle completion pulse
//   misaligned            misaligned-access flag, valid with done
//   c_valid, c_we         cache request pulse and write enable
//   c_addr, c_w_data      word-aligned cache address and full write word
//   c_r_data, c_ready     cache read data and one-cycle completion pulse
// ----------------------------------------------------------------------------
module lsu_cache_adapter #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    input  logic                  req_we,
    input  logic [2:0]            req_funct3,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_w_data,
    output logic                  stall,
    output logic [DATA_WIDTH-1:0] load_data,
    output logic                  done,
    output logic                  misaligned,
    output logic                  c_valid,
    output logic                  c_we,
    output logic [ADDR_WIDTH-1:0] c_addr,
    output logic [DATA_WIDTH-1:0] c_w_data,
    input  logic [DATA_WIDTH-1:0] c_r_data,
    input  logic                  c_ready
);

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StRdWait = 2'd1,
        StWrWait = 2'd2,
        StDone   = 2'd3
    } state_t;

    state_t                r_state,      w_state_d;
    logic [2:0]            r_funct3,     w_funct3_d;
    logic [1:0]            r_lane,       w_lane_d;
    logic [DATA_WIDTH-1:0] r_w_data,     w_w_data_d;
    logic                  r_rmw,        w_rmw_d;
    logic                  r_c_valid,    w_c_valid_d;
    logic                  r_c_we,       w_c_we_d;
    logic [ADDR_WIDTH-1:0] r_c_addr,     w_c_addr_d;
    logic [DATA_WIDTH-1:0] r_c_w_data,   w_c_w_data_d;
    logic [DATA_WIDTH-1:0] r_load_data,  w_load_data_d;
    logic                  r_done,       w_done_d;
    logic                  r_misaligned, w_misaligned_d;

    logic                  w_misalign;
    logic                  w_store_word;
    logic [7:0]            w_byte;
    logic [15:0]           w_half;
    logic [DATA_WIDTH-1:0] w_load_ext;
    logic [DATA_WIDTH-1:0] w_merge;

    // Alignment check on the incoming request (only consulted in StIdle).
`ifdef LSU_MISALIGN_CHECK_EN
    always_comb begin
        w_misalign = 1'b0;
        if (req_funct3[1:0] == 2'b01) begin
            w_misalign = req_addr[0];
        end else if (req_funct3[1]) begin
            // funct3[1:0] of 2 or 3 is a word access
            w_misalign = (req_addr[1:0] != 2'b00);
        end
    end
`else
    assign w_misalign = 1'b0;
`endif

    // Store funct3[1:0] of 2 or 3 is a full-word store; no read needed.
    assign w_store_word = req_we && req_funct3[1];

    // Load lane extraction and extension.
    always_comb begin
        w_byte = c_r_data[7:0];
        case (r_lane)
            2'd0: w_byte = c_r_data[7:0];
            2'd1: w_byte = c_r_data[15:8];
            2'd2: w_byte = c_r_data[23:16];
            2'd3: w_byte = c_r_data[31:24];
            default: w_byte = c_r_data[7:0];
        endcase
        w_half = r_lane[1] ? c_r_data[31:16] : c_r_data[15:0];

        case (r_funct3)
            3'b000:  w_load_ext = {{24{w_byte[7]}}, w_byte};
            3'b001:  w_load_ext = {{16{w_half[15]}}, w_half};
            3'b100:  w_load_ext = {24'd0, w_byte};
            3'b101:  w_load_ext = {16'd0, w_half};
            default: w_load_ext = c_r_data;
        endcase
    end

    // Sub-word store merge into the word just read.
    always_comb begin
        w_merge = c_r_data;
        case (r_funct3[1:0])
            2'b00: begin
                case (r_lane)
                    2'd0: w_merge[7:0]   = r_w_data[7:0];
                    2'd1: w_merge[15:8]  = r_w_data[7:0];
                    2'd2: w_merge[23:16] = r_w_data[7:0];
                    2'd3: w_merge[31:24] = r_w_data[7:0];
                    default: w_merge = c_r_data;
                endcase
            end
            2'b01: begin
                if (r_lane[1]) begin
                    w_merge[31:16] = r_w_data[15:0];
                end else begin
                    w_merge[15:0] = r_w_data[15:0];
                end
            end
            default: w_merge = r_w_data;
        endcase
    end

    // Next-state and registered-output logic.
    always_comb begin
        w_state_d      = r_state;
        w_funct3_d     = r_funct3;
        w_lane_d       = r_lane;
        w_w_data_d     = r_w_data;
        w_rmw_d        = r_rmw;
        w_c_valid_d    = 1'b0;  // c_valid is a strict one-cycle pulse
        w_c_we_d       = r_c_we;
        w_c_addr_d     = r_c_addr;
        w_c_w_data_d   = r_c_w_data;
        w_load_data_d  = r_load_data;
        w_done_d       = 1'b0;
        w_misaligned_d = 1'b0;

        case (r_state)
            StIdle: begin
                if (req_valid) begin
                    w_funct3_d = req_funct3;
                    w_lane_d   = req_addr[1:0];
                    w_w_data_d = req_w_data;
                    if (w_misalign) begin
                        w_state_d      = StDone;
                        w_done_d       = 1'b1;
                        w_misaligned_d = 1'b1;
                        w_load_data_d  = '0;
                    end else begin
                        w_c_valid_d = 1'b1;
                        w_c_addr_d  = {req_addr[ADDR_WIDTH-1:2], 2'b00};
                        if (w_store_word) begin
                            w_c_we_d     = 1'b1;
                            w_c_w_data_d = req_w_data;
                            w_rmw_d      = 1'b0;
                            w_state_d    = StWrWait;
                        end else begin
                            w_c_we_d  = 1'b0;
                            w_rmw_d   = req_we;
                            w_state_d = StRdWait;
                        end
                    end
                end
            end
            StRdWait: begin
                if (c_ready) begin
                    if (r_rmw) begin
                        w_c_w_data_d = w_merge;
                        w_c_we_d     = 1'b1;
                        w_c_valid_d  = 1'b1;
                        w_state_d    = StWrWait;
                    end else begin
                        w_load_data_d = w_load_ext;
                        w_done_d      = 1'b1;
                        w_state_d     = StDone;
                    end
                end
            end
            StWrWait: begin
                if (c_ready) begin
                    w_done_d  = 1'b1;
                    w_state_d = StDone;
                end
            end
            StDone: begin
                w_state_d = StIdle;
            end
            default: begin
                w_state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= StIdle;
            r_funct3     <= 3'd0;
            r_lane       <= 2'd0;
            r_w_data     <= '0;
            r_rmw        <= 1'b0;
            r_c_valid    <= 1'b0;
            r_c_we       <= 1'b0;
            r_c_addr     <= '0;
            r_c_w_data   <= '0;
            r_load_data  <= '0;
            r_done       <= 1'b0;
            r_misaligned <= 1'b0;
        end else begin
            r_state      <= w_state_d;
            r_funct3     <= w_funct3_d;
            r_lane       <= w_lane_d;
            r_w_data     <= w_w_data_d;
            r_rmw        <= w_rmw_d;
            r_c_valid    <= w_c_valid_d;
            r_c_we       <= w_c_we_d;
            r_c_addr     <= w_c_addr_d;
            r_c_w_data   <= w_c_w_data_d;
            r_load_data  <= w_load_data_d;
            r_done       <= w_done_d;
            r_misaligned <= w_misaligned_d;
        end
    end

    // The pipeline advances only in the StDone cycle.
    assign stall      = req_valid && (r_state != StDone);
    assign load_data  = r_load_data;
    assign done       = r_done;
    assign misaligned = r_misaligned;
    assign c_valid    = r_c_valid;
    assign c_we       = r_c_we;
    assign c_addr     = r_c_addr;
    assign c_w_data   = r_c_w_data;

endmodule

// File: tb/tb_lsu_cache_adapter.sv
// ----------------------------------------------------------------------------
// tb_lsu_cache_adapter
//
// Directed bench for lsu_cache_adapter with a small behavioural cache: reads of
// a valid word answer c_ready the cycle after c_valid, reads of an invalid word
// take 4 more cycles (line fill), writes always answer the next cycle.
// ----------------------------------------------------------------------------
module tb_lsu_cache_adapter;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_w_data;
    logic        stall;
    logic [31:0] load_data;
    logic        done;
    logic        misaligned;
    logic        c_valid;
    logic        c_we;
    logic [31:0] c_addr;
    logic [31:0] c_w_data;
    logic [31:0] c_r_data;
    logic        c_ready;

    int checks = 0;
    int errors = 0;

    lsu_cache_adapter #(
        .ADDR_WIDTH(32),
        .DATA_WIDTH(32)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_we    (req_we),
        .req_funct3(req_funct3),
        .req_addr  (req_addr),
        .req_w_data(req_w_data),
        .stall     (stall),
        .load_data (load_data),
        .done      (done),
        .misaligned(misaligned),
        .c_valid   (c_valid),
        .c_we      (c_we),
        .c_addr    (c_addr),
        .c_w_data  (c_w_data),
        .c_r_data  (c_r_data),
        .c_ready   (c_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural cache; shares rst and reloads its contents on reset.
    logic [31:0] mem     [512];
    logic        line_ok [512];
    logic [8:0]  pend;
    int          fill_cnt;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            c_ready  <= 1'b0;
            c_r_data <= 32'd0;
            fill_cnt <= 0;
            pend     <= 9'd0;
            for (int i = 0; i < 512; i++) begin
                mem[i]     <= 32'd0;
                line_ok[i] <= 1'b0;
            end
            mem[9'h040] <= 32'h8000_FF7F;  line_ok[9'h040] <= 1'b1;  // 0x100
            mem[9'h080] <= 32'h1122_3344;  line_ok[9'h080] <= 1'b1;  // 0x200
            mem[9'h0C0] <= 32'h0000_0000;  line_ok[9'h0C0] <= 1'b1;  // 0x300
            mem[9'h100] <= 32'hDEAD_BEEF;                            // 0x400 cold
            mem[9'h101] <= 32'h0BAD_F00D;                            // 0x404 cold
        end else begin
            c_ready <= 1'b0;
            if (fill_cnt != 0) begin
                fill_cnt <= fill_cnt - 1;
                if (fill_cnt == 1) begin
                    c_ready       <= 1'b1;
                    c_r_data      <= mem[pend];
                    line_ok[pend] <= 1'b1;
                end
            end else if (c_valid) begin
                if (c_we) begin
                    mem[c_addr[10:2]] <= c_w_data;
                    c_ready           <= 1'b1;
                end else if (line_ok[c_addr[10:2]]) begin
                    c_r_data <= mem[c_addr[10:2]];
                    c_ready  <= 1'b1;
                end else begin
                    pend     <= c_addr[10:2];
                    fill_cnt <= 4;
                end
            end
        end
    end

    // Transaction monitor on the opposite edge.
    int          pulses;
    int          adjacent;
    logic        prev_valid;
    logic        tx_we   [$];
    logic [31:0] tx_addr [$];
    logic [31:0] tx_data [$];

    initial begin
        pulses     = 0;
        adjacent   = 0;
        prev_valid = 1'b0;
    end

    always @(negedge clk) begin
        if (c_valid) begin
            pulses++;
            tx_we.push_back(c_we);
            tx_addr.push_back(c_addr);
            tx_data.push_back(c_w_data);
            if (prev_valid) adjacent++;
        end
        prev_valid = c_valid;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Issue one request at the current cycle (cycle 0) and hold it until done.
    task automatic run_op(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wd, output int done_cyc,
                          output logic [31:0] ld, output logic mis,
                          output logic [31:0] stall_mask);
        tx_we.delete();
        tx_addr.delete();
        tx_data.delete();
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_w_data = wd;
        done_cyc   = -1;
        ld         = 32'hxxxx_xxxx;
        mis        = 1'bx;
        stall_mask = 32'd0;
        #1;
        for (int c = 0; c < 20; c++) begin
            stall_mask[c] = stall;
            if (done) begin
                done_cyc = c;
                ld       = load_data;
                mis      = misaligned;
                break;
            end
            @(posedge clk);
            #2;
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        #1;
    endtask

    int          dc;
    logic [31:0] ld;
    logic        mis;
    logic [31:0] sm;
    int          p0;

    initial begin
        rst        = 1'b1;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_funct3 = 3'd0;
        req_addr   = 32'd0;
        req_w_data = 32'd0;
        #12;
        check("rst_c_valid",   {31'd0, c_valid},    32'd0);
        check("rst_c_addr",    c_addr,              32'd0);
        check("rst_load_data", load_data,           32'd0);
        check("rst_done",      {31'd0, done},       32'd0);
        check("rst_stall",     {31'd0, stall},      32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #2;

        // Idle with no request: no cache activity.
        p0 = pulses;
        repeat (3) @(posedge clk);
        #2;
        check("idle_no_pulse", 32'(pulses - p0), 32'd0);
        check("idle_stall",    {31'd0, stall},   32'd0);

        // Loads from 0x100 = 0x8000_FF7F (hit).
        run_op(1'b0, 3'b000, 32'h100, 32'd0, dc, ld, mis, sm);
        check("lb100_cyc", 32'(dc), 32'd3);
        check("lb100_data", ld, 32'h0000_007F);
        check("lb100_done_pulse", {31'd0, done}, 32'd0);
        run_op(1'b0, 3'b000, 32'h101, 32'd0, dc, ld, mis, sm);
        check("lb101_data", ld, 32'hFFFF_FFFF);
        run_op(1'b0, 3'b100, 32'h101, 32'd0, dc, ld, mis, sm);
        check("lbu101_data", ld, 32'h0000_00FF);
        run_op(1'b0, 3'b001, 32'h102, 32'd0, dc, ld, mis, sm);
        check("lh102_data", ld, 32'hFFFF_8000);
        check("lh102_stall", sm, 32'h0000_0007);
        check("lh102_rd_addr", tx_addr[0], 32'h0000_0100);
        run_op(1'b0, 3'b101, 32'h102, 32'd0, dc, ld, mis, sm);
        check("lhu102_data", ld, 32'h0000_8000);

        // SB 0x203 into 0x1122_3344: read then merged write.
        p0 = pulses;
        run_op(1'b1, 3'b000, 32'h203, 32'h0000_00AB, dc, ld, mis, sm);
        check("sb_cyc", 32'(dc), 32'd5);
        check("sb_pulses", 32'(pulses - p0), 32'd2);
        check("sb_rd_we", {31'd0, tx_we[0]}, 32'd0);
        check("sb_wr_we", {31'd0, tx_we[1]}, 32'd1);
        check("sb_wr_addr", tx_addr[1], 32'h0000_0200);
        check("sb_wr_data", tx_data[1], 32'hAB22_3344);
        run_op(1'b0, 3'b010, 32'h200, 32'd0, dc, ld, mis, sm);
        check("lw200_data", ld, 32'hAB22_3344);

        // SH 0x202 then LHU readback.
        run_op(1'b1, 3'b001, 32'h202, 32'hFFFF_1234, dc, ld, mis, sm);
        check("sh_wr_data", tx_data[1], 32'h1234_3344);
        run_op(1'b0, 3'b101, 32'h202, 32'd0, dc, ld, mis, sm);
        check("lhu202_data", ld, 32'h0000_1234);

        // Load miss on cold 0x400.
        p0 = pulses;
        run_op(1'b0, 3'b010, 32'h400, 32'd0, dc, ld, mis, sm);
        check("miss_cyc", 32'(dc), 32'd7);
        check("miss_pulses", 32'(pulses - p0), 32'd1);
        check("miss_data", ld, 32'hDEAD_BEEF);

        // SW then LW back to back.
        p0 = adjacent;
        run_op(1'b1, 3'b010, 32'h300, 32'hCAFE_F00D, dc, ld, mis, sm);
        check("sw_cyc", 32'(dc), 32'd3);
        check("sw_wr_data", tx_data[0], 32'hCAFE_F00D);
        run_op(1'b0, 3'b010, 32'h300, 32'd0, dc, ld, mis, sm);
        check("b2b_lw_cyc", 32'(dc), 32'd3);
        check("b2b_lw_data", ld, 32'hCAFE_F00D);
        check("b2b_adjacent", 32'(adjacent - p0), 32'd0);

        // Misaligned word load.
        p0 = pulses;
        run_op(1'b0, 3'b010, 32'h102, 32'd0, dc, ld, mis, sm);
`ifdef LSU_MISALIGN_CHECK_EN
        check("mis_cyc", 32'(dc), 32'd1);
        check("mis_flag", {31'd0, mis}, 32'd1);
        check("mis_data", ld, 32'd0);
        check("mis_pulses", 32'(pulses - p0), 32'd0);
`else
        check("mis_cyc", 32'(dc), 32'd3);
        check("mis_flag", {31'd0, mis}, 32'd0);
        check("mis_data", ld, 32'h8000_FF7F);
        check("mis_pulses", 32'(pulses - p0), 32'd1);
`endif

        // Reset while waiting on a cold-line read.
        req_valid  = 1'b1;
        req_we     = 1'b0;
        req_funct3 = 3'b010;
        req_addr   = 32'h404;
        req_w_data = 32'd0;
        @(posedge clk);
        #2;
        check("rstmid_c_valid_pre", {31'd0, c_valid}, 32'd1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        rst       = 1'b1;
        #1;
        check("rstmid_c_valid",    {31'd0, c_valid},    32'd0);
        check("rstmid_c_we",       {31'd0, c_we},       32'd0);
        check("rstmid_c_addr",     c_addr,              32'd0);
        check("rstmid_c_w_data",   c_w_data,            32'd0);
        check("rstmid_load_data",  load_data,           32'd0);
        check("rstmid_done",       {31'd0, done},       32'd0);
        check("rstmid_misaligned", {31'd0, misaligned}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #2;
        run_op(1'b0, 3'b010, 32'h100, 32'd0, dc, ld, mis, sm);
        check("post_rst_cyc", 32'(dc), 32'd3);
        check("post_rst_data", ld, 32'h8000_FF7F);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
